tcp_vlg_tx_arb: RTL



---
 rtl/tcp_vlg_pkg.sv | 29 ++
 rtl/tcp_vlg_tx_arb_if.sv | 32 +++
 rtl/tcp_vlg_tx_arb.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/tcp_vlg_pkg.sv
// ---------------------------------------------------------------------------
// tcp_vlg_pkg
// Shared types for the TCP engine blocks.
//   tcp_stat_t : connection state as reported by the connection FSM
//   tx_kind_t  : kind of packet the TX packet engine is asked to assemble
//   max_int    : elaboration-time helper for sizing shared counters
// ---------------------------------------------------------------------------
package tcp_vlg_pkg;

    typedef enum logic [2:0] {
        tcp_closed        = 3'd0,
        tcp_listening     = 3'd1,
        tcp_connecting    = 3'd2,
        tcp_connected     = 3'd3,
        tcp_disconnecting = 3'd4
    } tcp_stat_t;

    typedef enum logic [1:0] {
        TX_CTL = 2'd0,
        TX_RTX = 2'd1,
        TX_DAT = 2'd2,
        TX_ACK = 2'd3
    } tx_kind_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tcp_vlg_tx_arb_if.sv
// ---------------------------------------------------------------------------
// tcp_vlg_tx_arb_if
// Handshake between the TX scheduler and the TX packet-assembly engine.
//   tx_start : scheduler -> engine, one-cycle pulse, begin a packet
//   tx_kind  : scheduler -> engine, packet kind, stable for the whole packet
//   tx_abort : scheduler -> engine, one-cycle pulse, watchdog expired
//   tx_done  : engine -> scheduler, one-cycle pulse, packet finished
// master = scheduler side, slave = engine side.
// ---------------------------------------------------------------------------
interface tcp_vlg_tx_arb_if;
    import tcp_vlg_pkg::*;

    logic     tx_start;
    tx_kind_t tx_kind;
    logic     tx_abort;
    logic     tx_done;

    modport master (
        output tx_start,
        output tx_kind,
        output tx_abort,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_kind,
        input  tx_abort,
        output tx_done
    );

endinterface

// File: rtl/tcp_vlg_tx_arb.sv
// ---------------------------------------------------------------------------
// tcp_vlg_tx_arb
// Per-connection TX scheduler. Shares the single packet-assembly engine
// between control, retransmit, new-data and pure-ack requesters, serialises
// packets with an inter-frame gap and guards each one with a watchdog.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   status          connection state; only ctl is served unless connected
//   req_ctl/rtx/dat level requests, held by the requester until its done
//   req_ack         pure-ack request from the ack generator
//   eng             engine handshake (tx_start/tx_kind/tx_abort/tx_done)
//   done_ctl..ack   one-cycle completion pulse to the owning requester
//   ack_sent        one-cycle pulse on every completed packet
//   err_timeout     sticky watchdog-abort flag
//   busy            high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module tcp_vlg_tx_arb
    import tcp_vlg_pkg::*;
#(
    parameter int IFG_TICKS    = 12,
    parameter int DONE_TIMEOUT = 10000,
    parameter int STARVE_LIMIT = 4,
    parameter int VERBOSE      = 0,
    parameter     DUT_STRING   = ""
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  tcp_stat_t               status,
    input  logic                    req_ctl,
    input  logic                    req_rtx,
    input  logic                    req_dat,
    input  logic                    req_ack,
    tcp_vlg_tx_arb_if.master        eng,
    output logic                    done_ctl,
    output logic                    done_rtx,
    output logic                    done_dat,
    output logic                    done_ack,
    output logic                    ack_sent,
    output logic                    err_timeout,
    output logic                    busy
);

    // Watchdog and gap never run at the same time, so one counter serves both.
    localparam int CNT_MAX = max_int(DONE_TIMEOUT, IFG_TICKS);
    localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int SW_RAW  = $clog2(STARVE_LIMIT + 1);
    localparam int SW      = (SW_RAW < 1) ? 1 : SW_RAW;

    localparam logic [CW-1:0] TO_LAST    = CW'((DONE_TIMEOUT > 0) ? DONE_TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] IFG_LAST   = CW'((IFG_TICKS > 0) ? IFG_TICKS - 1 : 0);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    // Display messages are not produced by synthesizable code; the two
    // parameters are kept so existing instantiations elaborate unchanged.
    if ((VERBOSE != 0) && ($bits(DUT_STRING) > 0)) begin : g_verbose
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    tx_kind_t        kind_q, kind_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            err_q, err_d;

    logic            connected;
    logic            grant_valid;
    tx_kind_t        grant_kind;
    logic            done_evt;
    logic            expire_evt;
    logic [3:0]      done_vec;

    // ---------------------------------------------------------------------
    // Priority select: ctl > rtx > dat > ack, with dat promoted above rtx
    // once rtx has won STARVE_LIMIT times in a row while dat was waiting.
    // Outside the connected state only control packets may go out.
    // ---------------------------------------------------------------------
    always_comb begin
        connected   = (status == tcp_connected);
        grant_valid = 1'b1;
        grant_kind  = TX_CTL;
        if (req_ctl) begin
            grant_kind = TX_CTL;
        end else if (!connected) begin
            grant_valid = 1'b0;
        end else if (req_dat && (starve_q == STARVE_MAX)) begin
            grant_kind = TX_DAT;
        end else if (req_rtx) begin
            grant_kind = TX_RTX;
        end else if (req_dat) begin
            grant_kind = TX_DAT;
        end else if (req_ack) begin
            grant_kind = TX_ACK;
        end else begin
            grant_valid = 1'b0;
        end
    end

    // A tx_done in the expiry cycle counts as a completion, not an abort.
    assign done_evt   = (state_q == S_BUSY) && eng.tx_done;
    assign expire_evt = (state_q == S_BUSY) && !eng.tx_done && (cnt_q == TO_LAST);

    for (genvar gi = 0; gi < 4; gi++) begin : g_done
        assign done_vec[gi] = done_evt && (kind_q == tx_kind_t'(gi));
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            kind_q   <= TX_CTL;
            cnt_q    <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        err_d    = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (!req_dat) begin
                    starve_d = '0;
                end
                if (grant_valid) begin
                    kind_d  = grant_kind;
                    state_d = S_START;
                    if (grant_kind == TX_DAT) begin
                        starve_d = '0;
                    end else if ((grant_kind == TX_RTX) && req_dat &&
                                 (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end

            S_START: begin
                cnt_d   = '0;
                state_d = S_BUSY;
            end

            S_BUSY: begin
                if (done_evt || expire_evt) begin
                    cnt_d   = '0;
                    state_d = (IFG_TICKS == 0) ? S_IDLE : S_GAP;
                    if (expire_evt) begin
                        err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        eng.tx_start = (state_q == S_START);
        eng.tx_kind  = kind_q;
        eng.tx_abort = expire_evt;
        ack_sent     = done_evt;
        busy         = (state_q != S_IDLE);
        done_ctl     = done_vec[0];
        done_rtx     = done_vec[1];
        done_dat     = done_vec[2];
        done_ack     = done_vec[3];
        err_timeout  = err_q;
    end

endmodule
